// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// active-low hex segment table, blanked pattern and slot-phase encoding.
package ssd_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // abcdefg, active low; entry 15 is leftmost so SEG_CODES[v] decodes v
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef enum logic [1:0] {
        PH_BLANK,
        PH_ON,
        PH_OFF
    } phase_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return SEG_CODES[value];
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-digit to active-low seven-segment decoder.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(value);

endmodule

// File: rtl/ssd_scan_scheduler.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display with dead time, brightness PWM and a tear-free double-buffered update
// port. Define SSD_LZB_EN to enable leading-zero blanking.
module ssd_scan_scheduler
    import ssd_pkg::*;
#(
    parameter int N     = 4,
    parameter int DIV   = 1024,
    parameter int BLANK = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*4-1:0] upd_numbers,
    input  logic           upd_valid,
    output logic           upd_ready,
    input  logic [3:0]     brightness,
    output logic [N-1:0]   displays,
    output logic [6:0]     segments,
    output logic           frame_done
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(N);
    localparam int LW = CW + 1;
    localparam int unsigned SPAN = DIV - BLANK;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [LW-1:0]       on_len;
    logic [LW-1:0]       on_len_next;
    logic [N-1:0][3:0]   shadow;
    logic [N-1:0][3:0]   pend_data;
    logic                pend_valid;
    logic                slot_end;
    logic                frame_end;
    logic                xfer;
    phase_e              phase;
    logic [3:0]          digit;
    logic [6:0]          seg_code;
    logic                digit_blank;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign xfer      = upd_valid && upd_ready;

    // Full-precision product before the shift; it never exceeds DIV-BLANK.
    assign on_len_next = LW'((SPAN * (32'(brightness) + 32'd1)) >> 4);

    assign digit = shadow[idx];

    ssd_hex_decoder u_dec (
        .value (digit),
        .seg   (seg_code)
    );

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        phase = PH_OFF;
        if (cnt < BLANK_END)
            phase = PH_BLANK;
        else if (LW'(cnt) < LW'(BLANK) + on_len)
            phase = PH_ON;
    end

`ifdef SSD_LZB_EN
    logic [N-1:0] lead_zero;

    // lead_zero[i]: digit i and every digit above it hold zero
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = N - 1; i >= 0; i--) begin
            run          = run && (shadow[i] == 4'h0);
            lead_zero[i] = run;
        end
    end

    assign digit_blank = (idx != '0) && lead_zero[idx];
`else
    assign digit_blank = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            idx    <= '0;
            on_len <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == '0)
                on_len <= on_len_next;
        end
    end

    // NOTE: the data registers are reset too, so a reset always restarts from a blank shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_data  <= '0;
            pend_valid <= 1'b0;
            shadow     <= '0;
            upd_ready  <= 1'b1;
        end else if (xfer) begin
            pend_data  <= upd_numbers;
            pend_valid <= 1'b1;
            upd_ready  <= 1'b0;
        end else if (frame_end && pend_valid) begin
            shadow     <= pend_data;
            pend_valid <= 1'b0;
            upd_ready  <= 1'b1;
        end
    end

    // Output stage: one cycle behind cnt/idx, off unless in the ON phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            displays   <= '1;
            segments   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            displays   <= '1;
            segments   <= SEG_OFF;
            if (phase == PH_ON && !digit_blank) begin
                displays <= ~(N'(1) << idx);
                segments <= seg_code;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Directed bench for ssd_scan_scheduler with N=4, DIV=16, BLANK=2.
module tb_ssd_scan_scheduler;

    localparam int N     = 4;
    localparam int DIV   = 16;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] upd_numbers = '0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  brightness = '0;
    logic [3:0]  displays;
    logic [6:0]  segments;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int model_b     = 0;
    logic [15:0] cur_sh = '0;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    ssd_scan_scheduler #(.N(N), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_numbers (upd_numbers),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .brightness  (brightness),
        .displays    (displays),
        .segments    (segments),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Brightness is latched by the model at each slot start, as the display should.
    task automatic step();
        if (cyc % DIV == 0) model_b = int'(brightness);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic bit lz_blank(int d, logic [15:0] sh);
`ifdef SSD_LZB_EN
        if (d == 0) return 1'b0;
        for (int i = d; i < N; i++)
            if (sh[i*4 +: 4] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_on(int k, int b, logic [15:0] sh);
        int c, d, len;
        if (k <= 0) return 1'b0;
        c   = (k - 1) % DIV;
        d   = ((k - 1) / DIV) % N;
        len = ((DIV - BLANK) * (b + 1)) >> 4;
        return (c >= BLANK) && (c < BLANK + len) && !lz_blank(d, sh);
    endfunction

    function automatic logic [3:0] exp_disp(int k, int b, logic [15:0] sh);
        int d;
        d = ((k - 1) / DIV) % N;
        if (exp_on(k, b, sh)) return ~(4'b0001 << d);
        return 4'hF;
    endfunction

    function automatic logic [6:0] exp_seg(int k, int b, logic [15:0] sh);
        int d;
        d = ((k - 1) / DIV) % N;
        if (exp_on(k, b, sh)) return seg_tab[sh[d*4 +: 4]];
        return 7'h7F;
    endfunction

    task automatic test_reset();
        int lows;
        rst = 1'b0;
        brightness = 4'd15;
        repeat (2) @(negedge clk);
        vectors++; if (displays !== 4'hF) begin miscompares++; $display("FAIL rst_disp got %h want f", displays); end
        vectors++; if (segments !== 7'h7F) begin miscompares++; $display("FAIL rst_seg got %h want 7f", segments); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_fd got %b want 0", frame_done); end
        vectors++; if (upd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", upd_ready); end
        rst = 1'b1;
        cyc = 0;
        cur_sh = '0;
        lows = 0;
        repeat (FRAME) begin
            step();
            if (cyc <= DIV && displays[0] === 1'b0) lows++;
            vectors++; if (displays !== exp_disp(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL b15_disp cyc=%0d got %h want %h", cyc, displays, exp_disp(cyc, model_b, cur_sh)); end
            vectors++; if (segments !== exp_seg(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL b15_seg cyc=%0d got %h want %h", cyc, segments, exp_seg(cyc, model_b, cur_sh)); end
            vectors++; if (frame_done !== (cyc % FRAME == 0)) begin miscompares++; $display("FAIL b15_fd cyc=%0d got %b", cyc, frame_done); end
        end
        vectors++; if (lows != 14) begin miscompares++; $display("FAIL b15_on_len got %0d want 14", lows); end
    endtask

    task automatic test_brightness();
        int lows7, lows_mid, lows_dark;
        brightness = 4'd7;
        lows7 = 0; lows_mid = 0; lows_dark = 0;
        while (cyc < 3 * FRAME) begin
            if (cyc == 2 * FRAME + 8) brightness = 4'd0;
            step();
            if (cyc > FRAME && cyc <= FRAME + DIV && displays[0] === 1'b0) lows7++;
            if (cyc > 2 * FRAME && cyc <= 2 * FRAME + DIV && displays[0] === 1'b0) lows_mid++;
            if (cyc > 2 * FRAME + DIV && displays !== 4'hF) lows_dark++;
            vectors++; if (displays !== exp_disp(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL bri_disp cyc=%0d got %h want %h", cyc, displays, exp_disp(cyc, model_b, cur_sh)); end
            vectors++; if (segments !== exp_seg(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL bri_seg cyc=%0d got %h want %h", cyc, segments, exp_seg(cyc, model_b, cur_sh)); end
        end
        vectors++; if (lows7 != 7) begin miscompares++; $display("FAIL bri7_len got %0d want 7", lows7); end
        vectors++; if (lows_mid != 7) begin miscompares++; $display("FAIL bri_midslot got %0d want 7", lows_mid); end
        vectors++; if (lows_dark != 0) begin miscompares++; $display("FAIL bri0_dark got %0d want 0", lows_dark); end
        brightness = 4'd15;
    endtask

    task automatic test_update();
        int boundary;
        logic [15:0] sh;
        while (cyc % FRAME != 20) begin
            step();
            vectors++; if (displays !== exp_disp(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL upd_pre_disp cyc=%0d got %h", cyc, displays); end
        end
        vectors++; if (upd_ready !== 1'b1) begin miscompares++; $display("FAIL upd_ready_idle got %b want 1", upd_ready); end
        upd_numbers = 16'h1234;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        upd_numbers = '0;
        vectors++; if (upd_ready !== 1'b0) begin miscompares++; $display("FAIL upd_ready_drop got %b want 0", upd_ready); end
        boundary = (cyc / FRAME + 1) * FRAME;
        while (cyc < boundary + FRAME) begin
            step();
            sh = (cyc > boundary) ? 16'h1234 : cur_sh;
            vectors++; if (displays !== exp_disp(cyc, model_b, sh)) begin miscompares++; $display("FAIL upd_disp cyc=%0d got %h want %h", cyc, displays, exp_disp(cyc, model_b, sh)); end
            vectors++; if (segments !== exp_seg(cyc, model_b, sh)) begin miscompares++; $display("FAIL upd_seg cyc=%0d got %h want %h", cyc, segments, exp_seg(cyc, model_b, sh)); end
            vectors++; if (upd_ready !== (cyc >= boundary)) begin miscompares++; $display("FAIL upd_ready cyc=%0d got %b", cyc, upd_ready); end
            if (cyc == boundary + BLANK + 1) begin
                vectors++; if (segments !== 7'h4C) begin miscompares++; $display("FAIL upd_dig0 got %h want 4c", segments); end
            end
            if (cyc == boundary + 3 * DIV + BLANK + 1) begin
                vectors++; if ({displays, segments} !== {4'h7, 7'h4F}) begin miscompares++; $display("FAIL upd_dig3 got %h/%h want 7/4f", displays, segments); end
            end
        end
        cur_sh = 16'h1234;
    endtask

    task automatic test_frame_end_capture();
        int cap;
        logic [15:0] sh;
        while (cyc % FRAME != FRAME - 1) step();
        vectors++; if (upd_ready !== 1'b1) begin miscompares++; $display("FAIL fe_ready_pre got %b want 1", upd_ready); end
        upd_numbers = 16'hABCD;
        upd_valid = 1'b1;
        step();
        cap = cyc;
        vectors++; if (upd_ready !== 1'b0) begin miscompares++; $display("FAIL fe_ready_drop got %b want 0", upd_ready); end
        upd_numbers = 16'hFFFF;
        step();
        upd_valid = 1'b0;
        upd_numbers = '0;
        while (cyc < cap + 2 * FRAME) begin
            step();
            sh = (cyc > cap + FRAME) ? 16'hABCD : cur_sh;
            vectors++; if (displays !== exp_disp(cyc, model_b, sh)) begin miscompares++; $display("FAIL fe_disp cyc=%0d got %h want %h", cyc, displays, exp_disp(cyc, model_b, sh)); end
            vectors++; if (segments !== exp_seg(cyc, model_b, sh)) begin miscompares++; $display("FAIL fe_seg cyc=%0d got %h want %h", cyc, segments, exp_seg(cyc, model_b, sh)); end
            vectors++; if (upd_ready !== (cyc >= cap + FRAME)) begin miscompares++; $display("FAIL fe_ready cyc=%0d got %b", cyc, upd_ready); end
        end
        cur_sh = 16'hABCD;
    endtask

`ifdef SSD_LZB_EN
    task automatic test_lzb();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        int boundary, hi_on;
        logic [15:0] sh;
        for (int v = 0; v < 2; v++) begin
            upd_numbers = vals[v];
            upd_valid = 1'b1;
            step();
            upd_valid = 1'b0;
            boundary = (cyc / FRAME + 1) * FRAME;
            hi_on = 0;
            while (cyc < boundary + FRAME) begin
                step();
                sh = (cyc > boundary) ? vals[v] : cur_sh;
                if (cyc > boundary && displays[3:1] !== 3'b111 && v == 1) hi_on++;
                if (cyc > boundary && displays[3:2] !== 2'b11 && v == 0) hi_on++;
                vectors++; if (displays !== exp_disp(cyc, model_b, sh)) begin miscompares++; $display("FAIL lzb_disp cyc=%0d got %h want %h", cyc, displays, exp_disp(cyc, model_b, sh)); end
                vectors++; if (segments !== exp_seg(cyc, model_b, sh)) begin miscompares++; $display("FAIL lzb_seg cyc=%0d got %h want %h", cyc, segments, exp_seg(cyc, model_b, sh)); end
            end
            vectors++; if (hi_on != 0) begin miscompares++; $display("FAIL lzb_blanked v=%0d got %0d enables want 0", v, hi_on); end
            cur_sh = vals[v];
        end
    endtask
`endif

    task automatic test_reset_mid_slot();
        logic [3:0] mid_disp;
        while (cyc % FRAME != DIV + 5) step();
        upd_numbers = 16'h9999;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        upd_numbers = '0;
        while (cyc % FRAME != 2 * DIV + 6) step();
        mid_disp = lz_blank(2, cur_sh) ? 4'hF : 4'hB;
        vectors++; if (displays !== mid_disp) begin miscompares++; $display("FAIL mid_dig2 got %h want %h", displays, mid_disp); end
        #1 rst = 1'b0;
        #1;
        vectors++; if (displays !== 4'hF) begin miscompares++; $display("FAIL mid_rst_disp got %h want f", displays); end
        vectors++; if (segments !== 7'h7F) begin miscompares++; $display("FAIL mid_rst_seg got %h want 7f", segments); end
        vectors++; if (upd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", upd_ready); end
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        cur_sh = '0;
        repeat (FRAME + 20) begin
            step();
            vectors++; if (displays !== exp_disp(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL rst_scan_disp cyc=%0d got %h want %h", cyc, displays, exp_disp(cyc, model_b, cur_sh)); end
            vectors++; if (segments !== exp_seg(cyc, model_b, cur_sh)) begin miscompares++; $display("FAIL rst_scan_seg cyc=%0d got %h want %h", cyc, segments, exp_seg(cyc, model_b, cur_sh)); end
            vectors++; if (frame_done !== (cyc % FRAME == 0)) begin miscompares++; $display("FAIL rst_scan_fd cyc=%0d got %b", cyc, frame_done); end
        end
    endtask

    initial begin
        test_reset();
        test_brightness();
        test_update();
        test_frame_end_capture();
`ifdef SSD_LZB_EN
        test_lzb();
`endif
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ssd_scan_scheduler.md
# ssd_scan_scheduler

Time-multiplexing scan controller for an N-digit common-anode seven-segment display.
- Owns digit sequencing: per-digit time slots, anti-ghosting dead time, brightness PWM.
- Double-buffers the digit values behind a valid/ready update port, so a new value never tears mid-frame.
- Sits between the system-clock application logic and the board's display pins.

## Interface
- N, 4, number of digits (≥2)
- DIV, 1024, clock cycles per digit slot (> BLANK)
- BLANK, 32, dead-time cycles at the start of each slot (≥1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- upd_numbers  in  N*4  new hex digits, digit i at [i*4+3:i*4], digit 0 rightmost
- upd_valid  in  1  update request
- upd_ready  out  1  update port can accept
- brightness  in  4  0 = dark, 15 = maximum
- displays  out  N  digit enables, active low
- segments  out  7  abcdefg, active low
- frame_done  out  1  one-cycle pulse at end of last digit slot

## Operation
- Slot counter cnt runs 0..DIV-1; digit index idx runs 0..N-1 and wraps to 0.
- On cnt==DIV-1: cnt→0 and idx advances.
- Slot phases by cnt:
  - BLANK phase (cnt < BLANK): all displays off.
  - ON phase (BLANK ≤ cnt < BLANK+on_len): display idx driven.
  - OFF phase: remainder of slot, all displays off.
- on_len = ((DIV−BLANK)·(brightness+1)) >> 4, computed at full precision with no overflow. Brightness is sampled only at cnt==0 and held for the slot.
- Segment pattern is the hex decode of shadow digit idx:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, B=60, C=31, D=42, E=30, F=38.
  - During BLANK/OFF phases segments=7'h7F.
- Update handshake:
  - Transfer occurs when upd_valid && upd_ready.
  - The data is captured into a pending register; a pending flag is set and upd_ready drops.
  - At the frame-end cycle (cnt==DIV-1, idx==N-1), if the pending flag was already set before that cycle, pending is copied to shadow and the flag clears. upd_ready rises the following cycle.
  - A capture on the frame-end cycle itself is applied at the next frame end, not this one.
- upd_valid may drop without a transfer; there is no obligation to hold it.

## Timing
- Reset values (asynchronous assert):
  - displays = all 1s, segments = 7'h7F
  - frame_done = 0, upd_ready = 1
  - cnt = 0, idx = 0, shadow = 0, pending flag = 0
- All outputs are registered; each output reflects the cnt/idx values of the previous cycle.
  - After reset release, cycle 0 of slot 0 is seen on outputs at cycle 1.
  - Digit 0 ON starts on outputs at cycle BLANK+1.
- Frame length is exactly N·DIV cycles.
- frame_done is high for one cycle, one cycle after the frame-end cycle; it aligns with the first output cycle of slot 0.
- Shadow change is visible on segments from the next digit-0 ON phase.
- Reset mid-slot forces outputs off immediately; the scan restarts from digit 0 with pending discarded.
- Brightness change mid-slot takes effect at the next slot start.

## Configuration
- SSD_LZB_EN: leading-zero blanking.
  - Defined: working from digit N−1 downward, each digit whose shadow value is 0 and all of whose higher digits are 0 keeps displays off for its whole slot. Digit 0 is never blanked, so value 0 still shows "0". Slot timing is unchanged.
  - Undefined: all N digits are always shown.

## Structure
- Package ssd_pkg:
  - seven-segment code constants (the 16-entry active-low table)
  - SEG_OFF = 7'h7F
  - slot-phase enum {PH_BLANK, PH_ON, PH_OFF}
- Sub-module ssd_hex_decoder: 4-bit value in, 7-bit active-low pattern out, purely combinational, one instance muxed by idx.
- Scheduler keeps counter, phase FSM, pending/shadow registers and handshake in the top module.

## Test plan
All scenarios use N=4, DIV=16, BLANK=2.
- Reset then brightness=15, no update:
  - displays stays 4'hF for output cycles 1–2, then 4'hE for cycles 3–16.
  - segments=7'h01 during ON.
  - frame_done first pulses at cycle 64.
- brightness=7:
  - on_len=7; digit 0 low for exactly 7 cycles per slot.
  - brightness=0: on_len=0, displays never low.
- Update 16'h1234 with upd_valid mid-frame:
  - upd_ready drops next cycle; shadow unchanged until frame end.
  - Next frame shows digit 0 = 7'h4C, digit 3 = 7'h4F.
  - upd_ready re-asserts one cycle after frame end.
- upd_valid asserted exactly on the frame-end cycle:
  - The value appears only after the following frame end, 64 cycles later.
- SSD_LZB_EN defined, shadow 16'h0050:
  - Digits 3 and 2 never enabled; digits 1 and 0 show 7'h24 and 7'h01.
  - Shadow 16'h0000: only digit 0 shows 7'h01.
- Assert rst mid-ON of digit 2:
  - displays=4'hF and segments=7'h7F in the same cycle.
  - After release, the scan restarts at digit 0 with shadow 0.
